// File: rtl/shift_operand_stage.sv
// Operand2 decode stage feeding the barrel shifter.
// Decodes the ARM data-processing operand2 field into shift source, amount and
// operation, then holds the result in an output register backed by a one-entry
// skid register. In_Ready comes straight from skid occupancy, so a shifter
// stall never reaches decode combinationally.
module shift_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int PC_OFF_IMM = 8,
    parameter int PC_OFF_REG = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              Imm_Flag,
    input  logic [11:0]       Operand2,
    input  logic [DATA_W-1:0] Rm_Data,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic [DATA_W-1:0] PC_Value,
    input  logic              Carry_Flag,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Shift_Data,
    output logic [7:0]        Shift_Num,
    output logic [2:0]        SHIFT_OP,
    output logic              Carry_In,
    output logic              Illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [7:0]        num;
        logic [2:0]        op;
        logic              carry;
        logic              illegal;
    } entry_t;

    entry_t            dec;
    entry_t            out_q, out_d;
    entry_t            skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              accept;
    logic              drain;
    logic              rm_is_pc;
    logic [DATA_W-1:0] pc_off;
    logic [DATA_W-1:0] rm_val;
    logic              unused_rs_hi;

    // Only the low byte of Rs is a shift amount; the rest is ignored.
    assign unused_rs_hi = ^Rs_Data[DATA_W-1:8];

    // Reading R15 as Rm sees the pipelined PC; the offset depends on shift form.
    assign rm_is_pc = (Operand2[3:0] == 4'hF);
    assign pc_off   = Operand2[4] ? DATA_W'(PC_OFF_REG) : DATA_W'(PC_OFF_IMM);
    assign rm_val   = rm_is_pc ? (PC_Value + pc_off) : Rm_Data;

    // Operand2 decode into data/amount/op; amount-0 special cases are left to the shifter.
    always_comb begin
        dec       = '0;
        dec.carry = Carry_Flag;
        if (Imm_Flag) begin
            dec.data = DATA_W'(Operand2[7:0]);
            dec.num  = {3'b000, Operand2[11:8], 1'b0};
            dec.op   = 3'b111;
        end else if (!Operand2[4]) begin
            dec.data = rm_val;
            dec.num  = {3'b000, Operand2[11:7]};
            dec.op   = {Operand2[6:5], 1'b0};
        end else begin
            dec.data    = rm_val;
            dec.op      = {Operand2[6:5], 1'b1};
            dec.illegal = Operand2[7];
            dec.num     = Operand2[7] ? 8'h00 : Rs_Data[7:0];
        end
    end

    assign In_Ready = ~skid_valid_q;
    assign accept   = In_Valid & In_Ready;
    assign drain    = out_valid_q & Out_Ready;

    // Output/skid occupancy: flush wins, then skid refills output, then new accepts.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign Out_Valid  = out_valid_q;
    assign Shift_Data = out_q.data;
    assign Shift_Num  = out_q.num;
    assign SHIFT_OP   = out_q.op;
    assign Carry_In   = out_q.carry;
    assign Illegal    = out_q.illegal;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Testbench for shift_operand_stage: directed scenarios plus randomized traffic,
// with a queue-based scoreboard checked by an independent monitor.
module tb_shift_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        Flush;
    logic        In_Valid;
    logic        In_Ready;
    logic        Imm_Flag;
    logic [11:0] Operand2;
    logic [31:0] Rm_Data;
    logic [31:0] Rs_Data;
    logic [31:0] PC_Value;
    logic        Carry_Flag;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [2:0]  SHIFT_OP;
    logic        Carry_In;
    logic        Illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  num;
        logic [2:0]  op;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    shift_operand_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Flush      (Flush),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Imm_Flag   (Imm_Flag),
        .Operand2   (Operand2),
        .Rm_Data    (Rm_Data),
        .Rs_Data    (Rs_Data),
        .PC_Value   (PC_Value),
        .Carry_Flag (Carry_Flag),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Shift_Data (Shift_Data),
        .Shift_Num  (Shift_Num),
        .SHIFT_OP   (SHIFT_OP),
        .Carry_In   (Carry_In),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference decode from the architectural rules, in plain arithmetic.
    function automatic exp_t model(input logic imm, input logic [11:0] op2,
                                   input logic [31:0] rm, input logic [31:0] rs,
                                   input logic [31:0] pc, input logic c);
        exp_t        m;
        int unsigned f;
        int unsigned rm_idx;
        int unsigned shtype;
        bit          by_reg;
        logic [31:0] src;
        f      = op2;
        rm_idx = f % 16;
        by_reg = ((f / 16) % 2) == 1;
        shtype = (f / 32) % 4;
        src    = (rm_idx == 15) ? pc + (by_reg ? 32'd12 : 32'd8) : rm;
        m      = '0;
        m.c    = c;
        if (imm) begin
            m.data = 32'(f % 256);
            m.num  = 8'((f / 256) * 2);
            m.op   = 3'd7;
        end else if (!by_reg) begin
            m.data = src;
            m.num  = 8'(f / 128);
            m.op   = 3'(shtype * 2);
        end else begin
            m.data = src;
            m.ill  = ((f / 128) % 2) == 1;
            m.num  = m.ill ? 8'd0 : 8'(rs % 256);
            m.op   = 3'(shtype * 2 + 1);
        end
        return m;
    endfunction

    // Monitor: compares presented output with the queue head, tracks accepts/drains/flushes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("out_valid_occupancy", Out_Valid, sb.size() != 0);
            chk("in_ready_occupancy", In_Ready, sb.size() < 2);
            if (Out_Valid && sb.size() > 0) begin
                e = sb[0];
                chk("shift_data", Shift_Data, e.data);
                chk("shift_num", Shift_Num, e.num);
                chk("shift_op", SHIFT_OP, e.op);
                chk("carry_in", Carry_In, e.c);
                chk("illegal", Illegal, e.ill);
            end
            if (Out_Valid && Out_Ready && sb.size() > 0) void'(sb.pop_front());
            if (Flush) sb.delete();
            else if (In_Valid && In_Ready)
                sb.push_back(model(Imm_Flag, Operand2, Rm_Data, Rs_Data, PC_Value, Carry_Flag));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                          input logic [31:0] rs, input logic [31:0] pc, input logic c);
        Imm_Flag   = imm;
        Operand2   = op2;
        Rm_Data    = rm;
        Rs_Data    = rs;
        PC_Value   = pc;
        Carry_Flag = c;
        In_Valid   = 1'b1;
    endtask

    // Present an operand and hold it until the stage accepts it (bounded).
    task automatic drive(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                         input logic [31:0] rs, input logic [31:0] pc, input logic c);
        bit acc;
        acc = 0;
        set_in(imm, op2, rm, rs, pc, c);
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = In_Ready;
            cycle();
        end
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept @%0t", $time);
        end
        In_Valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        Imm_Flag = 1'b0; Operand2 = '0; Rm_Data = '0; Rs_Data = '0;
        PC_Value = '0; Carry_Flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_in_ready", In_Ready, 1);
        chk("rst_shift_data", Shift_Data, 0);
        chk("rst_shift_num", Shift_Num, 0);
        chk("rst_shift_op", SHIFT_OP, 0);
        chk("rst_carry_illegal", {Carry_In, Illegal}, 0);
        rst_n = 1'b1;
        cycle();

        // rotated immediate, visible the cycle after accept
        drive(1'b1, 12'h4FF, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
        chk("imm_valid", Out_Valid, 1);
        chk("imm_data", Shift_Data, 32'hFF);
        chk("imm_num", Shift_Num, 8);
        chk("imm_op", SHIFT_OP, 3'b111);
        Out_Ready = 1'b1; cycle(); Out_Ready = 1'b0;

        // LSR #32 form and register LSR
        drive(1'b0, 12'h021, 32'h8000_0001, 32'h0, 32'h0, 1'b0);
        chk("lsr32_num", Shift_Num, 0);
        chk("lsr32_op", SHIFT_OP, 3'b010);
        chk("lsr32_illegal", Illegal, 0);
        chk("lsr32_data", Shift_Data, 32'h8000_0001);
        Out_Ready = 1'b1; cycle(); Out_Ready = 1'b0;
        drive(1'b0, 12'h031, 32'h5, 32'h0000_0121, 32'h0, 1'b0);
        chk("reglsr_num", Shift_Num, 8'h21);
        chk("reglsr_op", SHIFT_OP, 3'b011);
        Out_Ready = 1'b1; cycle(); Out_Ready = 1'b0;

        // PC as Rm, immediate and register shift offsets
        drive(1'b0, 12'h00F, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFC, 1'b0);
        chk("pc_imm_data", Shift_Data, 32'h4);
        Out_Ready = 1'b1; cycle(); Out_Ready = 1'b0;
        drive(1'b0, 12'h11F, 32'hDEAD_BEEF, 32'h3, 32'h100, 1'b1);
        chk("pc_reg_data", Shift_Data, 32'h10C);
        Out_Ready = 1'b1; cycle(); Out_Ready = 1'b0;

        // backpressure: A to output, B to skid, C held off
        drive(1'b1, 12'h0A1, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 12'h0B2, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("bp_in_ready_low", In_Ready, 0);
        set_in(1'b1, 12'h0C3, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_ready", In_Ready, 0);
            chk("bp_hold_data", Shift_Data, 32'hA1);
        end
        Out_Ready = 1'b1;
        drive(1'b1, 12'h0C3, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) cycle();
        Out_Ready = 1'b0;

        // flush with full skid and a competing accept
        drive(1'b1, 12'h011, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 12'h022, 32'h0, 32'h0, 32'h0, 1'b0);
        set_in(1'b1, 12'h0DD, 32'h0, 32'h0, 32'h0, 1'b0);
        Flush = 1'b1;
        cycle();
        Flush = 1'b0; In_Valid = 1'b0;
        chk("flush_out_valid", Out_Valid, 0);
        chk("flush_in_ready", In_Ready, 1);
        Out_Ready = 1'b1;
        repeat (4) cycle();
        Out_Ready = 1'b0;

        // illegal register-shift encoding, then async reset mid-stall
        drive(1'b0, 12'h090, 32'h7777_0000, 32'h0000_00FF, 32'h0, 1'b1);
        chk("illegal_flag", Illegal, 1);
        chk("illegal_num", Shift_Num, 0);
        chk("illegal_op", SHIFT_OP, 3'b001);
        drive(1'b0, 12'h003, 32'h1, 32'h0, 32'h0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", Out_Valid, 0);
        chk("async_rst_in_ready", In_Ready, 1);
        chk("async_rst_illegal", Illegal, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        Out_Ready = 1'b1;
        repeat (3) cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Imm_Flag   = ($urandom_range(0, 3) == 0);
            Operand2   = 12'($urandom);
            if ($urandom_range(0, 3) == 0) Operand2[3:0] = 4'hF;
            Rm_Data    = $urandom;
            Rs_Data    = $urandom;
            PC_Value   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            Carry_Flag = 1'($urandom);
            In_Valid   = ($urandom_range(0, 99) < 70);
            Out_Ready  = ($urandom_range(0, 99) < 60);
            Flush      = ($urandom_range(0, 99) < 3);
            cycle();
        end
        In_Valid = 1'b0; Flush = 1'b0; Out_Ready = 1'b1;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
